rx_event_tracker: RTL and testbench
===================================

# rx_event_tracker

Parametrised successor of the per-channel receive-event bookkeeping stage between the channel data-write strobes and the readout path. It counts received events per channel and compares every enabled channel against the shared transmitted-event count. It raises `need_read` toward the tx manager when every enabled channel holds an unread event. It pulses `need_check` toward the L1A checker on the first readable event and on every single-step advance of the tx count.

## Interface
- `NUM_CH`, 16: number of receive channels (1..64).
- `CNT_W`, 16: width of per-channel rx counters and of `evt_tx` (4..32).
- `MAX_BACKLOG`, 2**(CNT_W-1)-1: backlog at which a channel flags overflow; must be < 2**(CNT_W-1).
- `clk` input 1: system clock; all logic on rising edge.
- `reset_n` input 1: reset, asynchronous, active-low.
- `clr` input 1: synchronous soft clear, same effect as reset.
- `din` input NUM_CH: per-channel one-cycle event pulse (falling-edge pulse of the data write request).
- `ch_mask` input NUM_CH: 1 = channel participates in `need_read`; quasi-static.
- `evt_tx` input CNT_W: count of events already read out; changes by at most +1 per cycle.
- `need_read` output 1: every enabled channel has backlog > 0.
- `need_check` output 1: one-cycle pulse, request L1A check.
- `ovf` output NUM_CH: sticky per-channel backlog overflow.
- `min_backlog` output CNT_W: smallest backlog across enabled channels.

## Operation
- Backlog(ch) = (evt_rx[ch] − evt_tx) mod 2**CNT_W. Interpret it as unsigned.
  - A value ≥ 2**(CNT_W−1) is treated as 0, meaning tx is ahead of rx.
  - Wrap of either counter is therefore transparent.
- `din[ch]`=1 → evt_rx[ch] += 1, modulo 2**CNT_W. There is no saturation.
- `need_read` = AND over enabled channels of backlog(ch) ≠ 0.
  - If `ch_mask` is all-zero, `need_read` = 0.
- `min_backlog` = minimum backlog over enabled channels. It is 0 if no channel is enabled.
- `ovf[ch]` sets when backlog(ch) ≥ MAX_BACKLOG. It clears only on reset or `clr`.
- `need_check` uses a single-bit `lock` state, ARMED → LOCKED.
  - **ARMED:** on the first cycle `need_read`_next = 1 while evt_tx = 0, pulse `need_check` and go to LOCKED.
  - **LOCKED:** pulse `need_check` whenever evt_tx − evt_tx_d = 1 (mod 2**CNT_W) and `need_read`_next = 1.
  - **Otherwise:** `need_check` = 0.
- `evt_tx_d` registers `evt_tx` every cycle.

## Timing
- Reset and `clr` values:
  - all evt_rx = 0
  - evt_tx_d = 0
  - lock = ARMED
  - `need_read` = 0
  - `need_check` = 0
  - `ovf` = 0
  - `min_backlog` = 0
- `clr` has priority over `din` in the same cycle.
- All outputs are registered. They are computed from next-state counters and the current `evt_tx`.
  - A `din` pulse in cycle N is reflected in `need_read` and `min_backlog` from cycle N+1.
  - An `evt_tx` change in cycle N is reflected from cycle N+1.
- `need_check` is high for exactly one cycle per qualifying event.
- Simultaneous `din[ch]` and `evt_tx` increment: backlog(ch) is unchanged.
- An `evt_tx` jump larger than 1 produces no `need_check`.
- Asynchronous reset mid-operation: outputs drop immediately. The first check after release again requires evt_tx = 0.

## Configuration
- `RX_SKEW_MON_EN`: compiles in a skew monitor with one parameter and two outputs.
  - Parameter `MAX_SKEW`, default 4.
  - `max_skew` (CNT_W): registered max−min backlog over enabled channels.
  - `skew_err` (1): sticky, set when `max_skew` > MAX_SKEW; cleared by reset or `clr`.
- Without the macro, these ports and this logic do not exist. All other behaviour is identical.

## Structure
- Package `rx_mgr_pkg` holds:
  - default `CNT_W`
  - the backlog-half-range constant
  - the lock state encoding, ARMED = 0 / LOCKED = 1
- Sub-module `rx_ch_counter` is instantiated NUM_CH times. It takes clk, reset_n, clr, din, evt_tx and produces backlog and ovf.
- Top level holds the mask, AND-reduce, min tree, lock FSM, evt_tx_d and the optional skew monitor.

## Test plan
- NUM_CH=16, mask all-ones, pulse `din` on channels 0..14 only → `need_read`=0. Pulse channel 15 → `need_read`=1 next cycle, `need_check` single pulse, `min_backlog`=1.
- Mask = 0x7FFF, pulse channels 0..14 once → `need_read`=1 with channel 15 idle. Mask=0 → `need_read`=0.
- All channels at 3 events, step `evt_tx` 0→1→2 one per 5 cycles → one `need_check` per step. Step 2→3 → `need_read`=0 and no pulse. Jump `evt_tx` 1→3 → no pulse.
- CNT_W=4: drive 20 events and `evt_tx` to 18 → backlog 2, `need_read`=1 across wrap. Keep `evt_tx` 0 while channel 0 reaches 7 → `ovf[0]`=1, sticky until `clr`.
- Assert `reset_n` low mid-stream → all outputs 0 asynchronously. Release, re-fill to 1 event each → `need_check` pulses again.
- With `RX_SKEW_MON_EN`, MAX_SKEW=4: channel 0 leads by 5 → `max_skew`=5, `skew_err`=1. Same stimulus without the macro → no skew ports.

Source files
------------

// File: rtl/rx_mgr_pkg.sv
// -----------------------------------------------------------------------------
// rx_mgr_pkg
// Shared definitions for the receive-event tracker:
//   - DEF_CNT_W       : default width of the rx counters and of evt_tx
//   - backlog_half()  : half of the counter range; a raw backlog at or above
//                       this value means tx is ahead of rx and reads as 0
//   - lock_e          : need_check lock state, ARMED = 0 / LOCKED = 1
// -----------------------------------------------------------------------------
package rx_mgr_pkg;

  localparam int DEF_CNT_W = 16;

  function automatic int unsigned backlog_half(input int cnt_w);
    return 32'd1 << (cnt_w - 1);
  endfunction

  localparam int unsigned DEF_BACKLOG_HALF = backlog_half(DEF_CNT_W);

  typedef enum logic {
    LOCK_ARMED  = 1'b0,
    LOCK_LOCKED = 1'b1
  } lock_e;

endpackage : rx_mgr_pkg

// File: rtl/rx_ch_counter.sv
// -----------------------------------------------------------------------------
// rx_ch_counter
// One receive channel: counts din pulses and derives the channel backlog
// against the shared transmitted-event count.
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : synchronous clear, wins over din
//   din          : one-cycle event pulse
//   evt_tx       : shared count of events already read out
//   backlog      : (next evt_rx - evt_tx) mod 2**CNT_W, folded to 0 when tx
//                  is ahead (combinational, feeds the registered top outputs)
//   ovf          : sticky, set once backlog reaches MAX_BACKLOG
// -----------------------------------------------------------------------------
module rx_ch_counter
  import rx_mgr_pkg::*;
#(
  parameter int          CNT_W       = DEF_CNT_W,
  parameter int unsigned MAX_BACKLOG = backlog_half(CNT_W) - 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             din,
  input  logic [CNT_W-1:0] evt_tx,
  output logic [CNT_W-1:0] backlog,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] HALF = CNT_W'(backlog_half(CNT_W));

  logic [CNT_W-1:0] r_evt_rx;
  logic [CNT_W-1:0] w_evt_rx_next;
  logic [CNT_W-1:0] w_raw;
  logic             r_ovf;

  // Backlog is taken from the next counter value so the registered outputs
  // at the top see the din of this cycle one cycle later, not two.
  always_comb begin
    w_evt_rx_next = clr ? '0 : r_evt_rx + CNT_W'(din);
    w_raw         = w_evt_rx_next - evt_tx;
    backlog       = (w_raw >= HALF) ? '0 : w_raw;
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_evt_rx <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_evt_rx <= w_evt_rx_next;
      if (clr)
        r_ovf <= 1'b0;
      else if (backlog >= CNT_W'(MAX_BACKLOG))
        r_ovf <= 1'b1;
    end
  end

  assign ovf = r_ovf;

endmodule : rx_ch_counter

// File: rtl/rx_event_tracker.sv
// -----------------------------------------------------------------------------
// rx_event_tracker
// Per-channel receive-event bookkeeping. Raises need_read when every enabled
// channel holds an unread event and pulses need_check on the first readable
// event after reset/clear and on every single-step advance of evt_tx.
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : synchronous soft clear (same effect as reset)
//   din          : per-channel event pulses
//   ch_mask      : 1 = channel participates in need_read / min / skew
//   evt_tx       : count of events already read out
//   need_read    : every enabled channel has backlog > 0 (registered)
//   need_check   : one-cycle L1A check request (registered)
//   ovf          : sticky per-channel backlog overflow
//   min_backlog  : smallest backlog across enabled channels (0 if none)
// Optional build macro RX_SKEW_MON_EN adds parameter MAX_SKEW and ports
//   max_skew     : registered max - min backlog over enabled channels
//   skew_err     : sticky, set when max_skew exceeds MAX_SKEW
// -----------------------------------------------------------------------------
module rx_event_tracker
  import rx_mgr_pkg::*;
#(
  parameter int          NUM_CH      = 16,
  parameter int          CNT_W       = DEF_CNT_W,
  parameter int unsigned MAX_BACKLOG = backlog_half(CNT_W) - 1
`ifdef RX_SKEW_MON_EN
  ,
  parameter int unsigned MAX_SKEW    = 4
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic [NUM_CH-1:0] din,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [CNT_W-1:0]  evt_tx,
  output logic              need_read,
  output logic              need_check,
  output logic [NUM_CH-1:0] ovf,
  output logic [CNT_W-1:0]  min_backlog
`ifdef RX_SKEW_MON_EN
  ,
  output logic [CNT_W-1:0]  max_skew,
  output logic              skew_err
`endif
);

  logic [CNT_W-1:0]  w_backlog [NUM_CH];
  logic [NUM_CH-1:0] w_nz;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    rx_ch_counter #(
      .CNT_W       (CNT_W),
      .MAX_BACKLOG (MAX_BACKLOG)
    ) u_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (clr),
      .din     (din[g]),
      .evt_tx  (evt_tx),
      .backlog (w_backlog[g]),
      .ovf     (ovf[g])
    );
    assign w_nz[g] = |w_backlog[g];
  end

  logic              w_need_read_next;
  logic [CNT_W-1:0]  w_min;
  logic [CNT_W-1:0]  w_max;
  logic [CNT_W-1:0]  w_tx_diff;
  logic              w_need_check_next;
  lock_e             r_lock;
  lock_e             w_lock_next;
  logic [CNT_W-1:0]  r_evt_tx_d;
  logic              r_need_read;
  logic              r_need_check;
  logic [CNT_W-1:0]  r_min_backlog;

  // Masked-off channels are forced to 1 so they never block the AND.
  assign w_need_read_next = (|ch_mask) & (&(w_nz | ~ch_mask));

  // NOTE: every signal driven here gets a default first, so no path through
  // the block can leave a value unassigned and infer a latch.
  always_comb begin
    w_min = '1;
    w_max = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_mask[i]) begin
        if (w_backlog[i] < w_min) w_min = w_backlog[i];
        if (w_backlog[i] > w_max) w_max = w_backlog[i];
      end
    end
    if (ch_mask == '0) w_min = '0;
  end

  // Lock FSM: the first check needs evt_tx = 0; afterwards only a +1 step of
  // evt_tx (mod 2**CNT_W) qualifies, so jumps never request a check.
  always_comb begin
    w_lock_next       = r_lock;
    w_need_check_next = 1'b0;
    w_tx_diff         = evt_tx - r_evt_tx_d;
    case (r_lock)
      LOCK_ARMED: begin
        if (w_need_read_next && (evt_tx == '0)) begin
          w_need_check_next = 1'b1;
          w_lock_next       = LOCK_LOCKED;
        end
      end
      LOCK_LOCKED: begin
        if (w_need_read_next && (w_tx_diff == CNT_W'(1)))
          w_need_check_next = 1'b1;
      end
      default: w_lock_next = LOCK_ARMED;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lock        <= LOCK_ARMED;
      r_evt_tx_d    <= '0;
      r_need_read   <= 1'b0;
      r_need_check  <= 1'b0;
      r_min_backlog <= '0;
    end else if (clr) begin
      r_lock        <= LOCK_ARMED;
      r_evt_tx_d    <= '0;
      r_need_read   <= 1'b0;
      r_need_check  <= 1'b0;
      r_min_backlog <= '0;
    end else begin
      r_lock        <= w_lock_next;
      r_evt_tx_d    <= evt_tx;
      r_need_read   <= w_need_read_next;
      r_need_check  <= w_need_check_next;
      r_min_backlog <= w_min;
    end
  end

  assign need_read   = r_need_read;
  assign need_check  = r_need_check;
  assign min_backlog = r_min_backlog;

`ifdef RX_SKEW_MON_EN
  logic [CNT_W-1:0] w_skew;
  logic [CNT_W-1:0] r_max_skew;
  logic             r_skew_err;

  // With no channel enabled both w_max and w_min are 0, giving skew 0.
  assign w_skew = w_max - w_min;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_max_skew <= '0;
      r_skew_err <= 1'b0;
    end else if (clr) begin
      r_max_skew <= '0;
      r_skew_err <= 1'b0;
    end else begin
      r_max_skew <= w_skew;
      if (w_skew > CNT_W'(MAX_SKEW)) r_skew_err <= 1'b1;
    end
  end

  assign max_skew = r_max_skew;
  assign skew_err = r_skew_err;
`else
  logic w_unused_max;
  assign w_unused_max = ^w_max;
`endif

endmodule : rx_event_tracker

// File: tb/tb_rx_event_tracker.sv
// -----------------------------------------------------------------------------
// tb_rx_event_tracker
// Directed and randomized stimulus; a reference model built on unbounded
// integer event counts predicts each cycle's outputs, which are queued and
// compared by an independent monitor one edge later.
// -----------------------------------------------------------------------------
module tb_rx_event_tracker;

  localparam int NUM_CH   = 16;
  localparam int CNT_W    = 4;
  localparam int MODV     = 1 << CNT_W;
  localparam int HALF     = MODV / 2;
  localparam int MAX_BL   = HALF - 1;
  localparam int MAX_SKEW = 4;

  logic              clk     = 1'b0;
  logic              reset_n = 1'b0;
  logic              clr     = 1'b0;
  logic [NUM_CH-1:0] din     = '0;
  logic [NUM_CH-1:0] ch_mask = '1;
  logic [CNT_W-1:0]  evt_tx  = '0;
  logic              need_read;
  logic              need_check;
  logic [NUM_CH-1:0] ovf;
  logic [CNT_W-1:0]  min_backlog;
`ifdef RX_SKEW_MON_EN
  logic [CNT_W-1:0]  max_skew;
  logic              skew_err;
`endif

  rx_event_tracker #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clr         (clr),
    .din         (din),
    .ch_mask     (ch_mask),
    .evt_tx      (evt_tx),
    .need_read   (need_read),
    .need_check  (need_check),
    .ovf         (ovf),
    .min_backlog (min_backlog)
`ifdef RX_SKEW_MON_EN
    ,
    .max_skew    (max_skew),
    .skew_err    (skew_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              nr;
    logic              nc;
    logic [NUM_CH-1:0] ovf;
    logic [CNT_W-1:0]  minb;
    logic [CNT_W-1:0]  skew;
    logic              skerr;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference state: plain event counts, never wrapped.
  int                rx_cnt [NUM_CH];
  int                tx_cnt;
  int                tx_d;
  bit                locked;
  logic [NUM_CH-1:0] m_ovf;
  bit                m_skerr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
    end
  endtask

  function automatic int modw(input int v);
    return ((v % MODV) + MODV) % MODV;
  endfunction

  function automatic int backlog(input int rx, input int tx);
    int r;
    r = modw(rx - tx);
    return (r >= HALF) ? 0 : r;
  endfunction

  task automatic model_reset();
    foreach (rx_cnt[i]) rx_cnt[i] = 0;
    tx_d    = 0;
    locked  = 0;
    m_ovf   = '0;
    m_skerr = 0;
  endtask

  task automatic model_step(input bit c, input logic [NUM_CH-1:0] d,
                            input logic [NUM_CH-1:0] m, output exp_t e);
    int bl, mn, mx, sk;
    bit all_nz;
    e = '{default: '0};
    if (c) begin
      model_reset();
      return;
    end
    all_nz = 1;
    mn     = MODV;
    mx     = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      rx_cnt[i] += int'(d[i]);
      bl = backlog(rx_cnt[i], tx_cnt);
      if (bl >= MAX_BL) m_ovf[i] = 1'b1;
      if (m[i]) begin
        if (bl == 0) all_nz = 0;
        if (bl < mn) mn = bl;
        if (bl > mx) mx = bl;
      end
    end
    e.nr   = (m != '0) && all_nz;
    e.minb = (m != '0) ? CNT_W'(mn) : '0;
    sk     = (m != '0) ? mx - mn : 0;
    if (sk > MAX_SKEW) m_skerr = 1;
    if (!locked) begin
      if (e.nr && modw(tx_cnt) == 0) begin
        e.nc   = 1'b1;
        locked = 1;
      end
    end else if (e.nr && modw(tx_cnt - tx_d) == 1) begin
      e.nc = 1'b1;
    end
    tx_d    = tx_cnt;
    e.ovf   = m_ovf;
    e.skew  = CNT_W'(sk);
    e.skerr = m_skerr;
  endtask

  // Drive one cycle's inputs (evt_tx from tx_cnt) and queue its prediction.
  task automatic cycle(input bit c, input logic [NUM_CH-1:0] d, input logic [NUM_CH-1:0] m);
    exp_t e;
    @(negedge clk);
    clr     = c;
    din     = d;
    ch_mask = m;
    evt_tx  = CNT_W'(tx_cnt);
    model_step(c, d, m, e);
    sb_q.push_back(e);
  endtask

  task automatic reset_checks();
    check("rst_need_read", need_read, 0);
    check("rst_need_check", need_check, 0);
    check("rst_ovf", ovf, 0);
    check("rst_min_backlog", min_backlog, 0);
`ifdef RX_SKEW_MON_EN
    check("rst_max_skew", max_skew, 0);
    check("rst_skew_err", skew_err, 0);
`endif
  endtask

  function automatic int min_all_backlog();
    int mn;
    mn = MODV;
    for (int i = 0; i < NUM_CH; i++)
      if (backlog(rx_cnt[i], tx_cnt) < mn) mn = backlog(rx_cnt[i], tx_cnt);
    return mn;
  endfunction

  // Monitor: outputs are registered, so each popped prediction belongs to
  // the edge just passed.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("need_read", need_read, e.nr);
        check("need_check", need_check, e.nc);
        check("ovf", ovf, e.ovf);
        check("min_backlog", min_backlog, e.minb);
`ifdef RX_SKEW_MON_EN
        check("max_skew", max_skew, e.skew);
        check("skew_err", skew_err, e.skerr);
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NUM_CH-1:0] m;
    bit                c;
    int                r;

    model_reset();
    tx_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_checks();
    @(negedge clk);
    reset_n = 1'b1;

    // Channel 15 alone holds need_read back.
    cycle(0, 16'h7FFF, '1);
    repeat (3) cycle(0, '0, '1);
    cycle(0, 16'h8000, '1);
    repeat (3) cycle(0, '0, '1);

    // Masked channel 15, then empty mask.
    cycle(1, '0, 16'h7FFF);
    cycle(0, 16'h7FFF, 16'h7FFF);
    repeat (2) cycle(0, '0, 16'h7FFF);
    repeat (2) cycle(0, '0, 16'h0000);

    // Three events each, evt_tx single steps 1, 2, 3.
    cycle(1, '0, '1);
    repeat (3) cycle(0, '1, '1);
    for (int t = 1; t <= 3; t++) begin
      tx_cnt = t;
      repeat (5) cycle(0, '0, '1);
    end

    // Jump 1 -> 3 gives no check.
    tx_cnt = 0;
    cycle(1, '0, '1);
    repeat (5) cycle(0, '1, '1);
    tx_cnt = 1;
    repeat (3) cycle(0, '0, '1);
    tx_cnt = 3;
    repeat (3) cycle(0, '0, '1);

    // 20 events vs evt_tx 18 across the 4-bit wrap.
    tx_cnt = 0;
    cycle(1, '0, '1);
    for (int i = 1; i <= 20; i++) begin
      tx_cnt = (i > 2) ? i - 2 : 0;
      cycle(0, '1, '1);
    end
    repeat (3) cycle(0, '0, '1);

    // Channel 0 reaches backlog 7: ovf sticky until clr.
    tx_cnt = 0;
    cycle(1, '0, '1);
    repeat (7) cycle(0, 16'h0001, 16'h0001);
    repeat (2) cycle(0, '0, 16'h0001);
    for (int t = 1; t <= 3; t++) begin
      tx_cnt = t;
      cycle(0, '0, 16'h0001);
    end
    tx_cnt = 0;
    cycle(1, '0, '1);
    cycle(0, '0, '1);

    // Channel 0 leads the rest by 5.
    cycle(1, '0, '1);
    cycle(0, '1, '1);
    repeat (5) cycle(0, 16'h0001, '1);
    repeat (2) cycle(0, '0, '1);

    // Asynchronous reset mid-stream, then refill.
    tx_cnt = 0;
    cycle(1, '0, '1);
    repeat (2) cycle(0, '1, '1);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    reset_checks();
    din    = '0;
    clr    = 1'b0;
    tx_cnt = 0;
    evt_tx = '0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    cycle(0, '1, '1);
    repeat (3) cycle(0, '0, '1);

    // Randomized traffic.
    tx_cnt = 0;
    m      = '1;
    cycle(1, '0, m);
    for (int n = 0; n < 400; n++) begin
      if (n % 64 == 63)
        m = ($urandom_range(0, 2) == 0) ? NUM_CH'($urandom) : '1;
      c = ($urandom_range(0, 99) == 0);
      if (c) begin
        tx_cnt = 0;
      end else begin
        r = $urandom_range(0, 9);
        if (r < 5 && min_all_backlog() > 0) tx_cnt += 1;
        else if (r == 5) tx_cnt += 2;
      end
      cycle(c, NUM_CH'($urandom), m);
    end

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_rx_event_tracker
